// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto one shared i2c_master.
// Optional WAIT watchdog is enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 100000,
  localparam int GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_reg,
  input  logic [8*N_REQ-1:0]   req_wdata,
  input  logic [N_REQ-1:0]     req_rd,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [7:0]           resp_rdata,
  output logic                 resp_err,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_din,
  output logic                 m_rd,
  output logic                 m_start,
  input  logic                 m_done,
  input  logic [7:0]           m_dout,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      din_q, din_d;
  logic            rd_q, rd_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [6:0] addr_a  [N_REQ];
  logic [7:0] reg_a   [N_REQ];
  logic [7:0] wdata_a [N_REQ];

  logic          found;
  logic [GW-1:0] win;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign addr_a[i]     = req_addr[7*i +: 7];
    assign reg_a[i]      = req_reg[8*i +: 8];
    assign wdata_a[i]    = req_wdata[8*i +: 8];
    assign resp_valid[i] = (state_q == S_RESP) && (grant_q == GW'(i));
  end

  // Round-robin search: starts just after the last winner and wraps.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[GW'(idx)]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  // Counter is zero outside WAIT, so it restarts from 0 on every WAIT entry.
  assign tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_hit   = (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
  assign resp_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    reg_d        = reg_q;
    din_d        = din_q;
    rd_d         = rd_q;
    rdata_d      = rdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_ISSUE;
          last_grant_d = win;
          grant_d      = win;
          addr_d       = addr_a[win];
          reg_d        = reg_a[win];
          din_d        = wdata_a[win];
          rd_d         = req_rd[win];
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (m_done) begin
          state_d = S_RESP;
          rdata_d = rd_q ? m_dout : 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          rdata_d = 8'h00;
          err_d   = 1'b1;
`endif
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(N_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      reg_q        <= '0;
      din_q        <= '0;
      rd_q         <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      reg_q        <= reg_d;
      din_q        <= din_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
    end
  end

  assign m_start    = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign m_addr     = addr_q;
  assign m_reg_addr = reg_q;
  assign m_din      = din_q;
  assign m_rd       = rd_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_i2c_txn_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [27:0]  req_addr;
  logic [31:0]  req_reg, req_wdata;
  logic [3:0]   req_rd;
  logic [3:0]   resp_valid;
  logic [7:0]   resp_rdata;
  logic         resp_err;
  logic [6:0]   m_addr;
  logic [7:0]   m_reg_addr, m_din;
  logic         m_rd, m_start, m_done, busy;
  logic [7:0]   m_dout;
  logic [1:0]   grant_id;

  logic [6:0] a_arr [4];
  logic [7:0] g_arr [4];
  logic [7:0] w_arr [4];
  logic       rd_arr[4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign req_addr[7*gi +: 7]  = a_arr[gi];
    assign req_reg[8*gi +: 8]   = g_arr[gi];
    assign req_wdata[8*gi +: 8] = w_arr[gi];
    assign req_rd[gi]           = rd_arr[gi];
  end

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_addr(m_addr), .m_reg_addr(m_reg_addr), .m_din(m_din), .m_rd(m_rd),
    .m_start(m_start), .m_done(m_done), .m_dout(m_dout), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: first requesting index after 'last', ascending with wrap.
  function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (r[idx]) return idx;
    end
    return 2'd0;
  endfunction

  typedef struct {
    bit         rst_before;
    logic [3:0] req;
    logic [1:0] win;
    logic [6:0] addr;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       rd;
    int         wcyc;
    logic [7:0] dout;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl[14];

  // Winner slot carries the listed fields; every other slot differs.
  task automatic drive_fields(input logic [1:0] win, input logic [6:0] addr,
                              input logic [7:0] rg, input logic [7:0] wd, input logic rd);
    for (int i = 0; i < 4; i++) begin
      a_arr[2'(i)]  = (2'(i) == win) ? addr : addr ^ 7'h2A;
      g_arr[2'(i)]  = (2'(i) == win) ? rg   : rg ^ 8'h5C;
      w_arr[2'(i)]  = (2'(i) == win) ? wd   : wd ^ 8'hA3;
      rd_arr[2'(i)] = (2'(i) == win) ? rd   : ~rd;
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      a_arr[2'(i)]  = 7'($urandom);
      g_arr[2'(i)]  = 8'($urandom);
      w_arr[2'(i)]  = 8'($urandom);
      rd_arr[2'(i)] = 1'($urandom);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic bad;
    drive_fields(v.win, v.addr, v.rg, v.wd, v.rd);
    req_valid = v.req;
    m_done = 1'b0;
    step();
    chk({tag, " m_start"}, 32'(m_start), 32'd1);
    chk({tag, " grant_id"}, 32'(grant_id), 32'(v.win));
    chk({tag, " m_addr"}, 32'(m_addr), 32'(v.addr));
    chk({tag, " m_reg_addr"}, 32'(m_reg_addr), 32'(v.rg));
    chk({tag, " m_din"}, 32'(m_din), 32'(v.wd));
    chk({tag, " m_rd"}, 32'(m_rd), 32'(v.rd));
    // Inputs churn while the transaction is in flight.
    req_valid = ~v.req;
    scramble();
    bad = 1'b0;
    for (int j = 0; j < v.wcyc; j++) begin
      step();
      if (m_start || resp_valid != 4'd0 || !busy) bad = 1'b1;
    end
    chk({tag, " quiet_wait"}, 32'(bad), 32'd0);
    m_done = 1'b1;
    m_dout = v.dout;
    req_valid = 4'd0;
    step();
    m_done = 1'b0;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'(4'b0001 << v.win));
    chk({tag, " resp_rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
    chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " m_addr_stable"}, 32'(m_addr), 32'(v.addr));
    step();
    chk({tag, " back_idle"}, 32'({busy, resp_valid}), 32'd0);
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] w, mlast;
    logic [6:0] sa;
    logic [7:0] sg, sw, d;
    logic       srd, bad;
    int         l;

    tbl[0]  = '{0, 4'b0001, 2'd0, 7'h76, 8'hF7, 8'h00, 1'b1, 10, 8'h5A, 8'h5A};
    tbl[1]  = '{0, 4'b0100, 2'd2, 7'h48, 8'hF4, 8'h27, 1'b0, 3,  8'hEE, 8'h00};
    tbl[2]  = '{1, 4'b1111, 2'd0, 7'h10, 8'h01, 8'h11, 1'b1, 1,  8'h81, 8'h81};
    tbl[3]  = '{0, 4'b1111, 2'd1, 7'h11, 8'h02, 8'h22, 1'b0, 2,  8'h99, 8'h00};
    tbl[4]  = '{0, 4'b1111, 2'd2, 7'h12, 8'h03, 8'h33, 1'b1, 4,  8'h3C, 8'h3C};
    tbl[5]  = '{0, 4'b1111, 2'd3, 7'h13, 8'h04, 8'h44, 1'b1, 1,  8'hC3, 8'hC3};
    tbl[6]  = '{0, 4'b1111, 2'd0, 7'h14, 8'h05, 8'h55, 1'b0, 2,  8'h77, 8'h00};
    tbl[7]  = '{0, 4'b1111, 2'd1, 7'h15, 8'h06, 8'h66, 1'b1, 3,  8'h01, 8'h01};
    tbl[8]  = '{0, 4'b1111, 2'd2, 7'h16, 8'h07, 8'h77, 1'b0, 1,  8'h42, 8'h00};
    tbl[9]  = '{0, 4'b1111, 2'd3, 7'h17, 8'h08, 8'h88, 1'b1, 2,  8'hFF, 8'hFF};
    tbl[10] = '{0, 4'b1010, 2'd1, 7'h20, 8'h10, 8'hA0, 1'b1, 1,  8'h5F, 8'h5F};
    tbl[11] = '{0, 4'b1010, 2'd3, 7'h21, 8'h11, 8'hA1, 1'b0, 2,  8'h5F, 8'h00};
    tbl[12] = '{0, 4'b1000, 2'd3, 7'h22, 8'h12, 8'hA2, 1'b1, 1,  8'h6E, 8'h6E};
    tbl[13] = '{0, 4'b0011, 2'd0, 7'h23, 8'h13, 8'hA3, 1'b1, 5,  8'h7D, 8'h7D};

    rst = 1'b1; req_valid = 4'd0; m_done = 1'b0; m_dout = 8'h00;
    scramble();
    step(); step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst m_start", 32'(m_start), 32'd0);
    chk("rst resp", 32'({resp_valid, resp_rdata, resp_err}), 32'd0);
    chk("rst m_fields", 32'({m_addr, m_reg_addr, m_din, m_rd}), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst_before) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Stray m_done in IDLE and in ISSUE must not complete anything.
    drive_fields(2'd0, 7'h31, 8'h32, 8'h34, 1'b1);
    m_done = 1'b1; req_valid = 4'd0;
    step();
    chk("spur idle resp", 32'({busy, resp_valid}), 32'd0);
    req_valid = 4'b0001;
    step();
    chk("spur m_start", 32'(m_start), 32'd1);
    req_valid = 4'd0;
    step();
    chk("spur issue resp", 32'(resp_valid), 32'd0);
    chk("spur still busy", 32'(busy), 32'd1);
    m_done = 1'b0;
    step();
    chk("spur wait resp", 32'(resp_valid), 32'd0);
    m_done = 1'b1; m_dout = 8'h33;
    step();
    m_done = 1'b0;
    chk("spur real resp", 32'(resp_valid), 32'd1);
    chk("spur rdata", 32'(resp_rdata), 32'h33);
    step();

    // Reset while waiting on the master drops the transaction.
    drive_fields(2'd2, 7'h55, 8'h66, 8'h77, 1'b1);
    req_valid = 4'b0100;
    step();
    chk("midrst m_start", 32'(m_start), 32'd1);
    req_valid = 4'd0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", 32'({busy, m_start}), 32'd0);
    chk("midrst resp", 32'({resp_valid, resp_rdata, resp_err}), 32'd0);
    chk("midrst m_fields", 32'({m_addr, m_reg_addr, m_din, m_rd}), 32'd0);
    chk("midrst grant_id", 32'(grant_id), 32'd0);
    m_done = 1'b1; m_dout = 8'hAB;
    step();
    m_done = 1'b0;
    chk("midrst late done", 32'({busy, resp_valid}), 32'd0);
    run_txn('{0, 4'b1111, 2'd0, 7'h40, 8'h41, 8'h42, 1'b1, 2, 8'h43, 8'h43}, "post_rst");

`ifdef I2C_ARB_TIMEOUT_EN
    drive_fields(2'd1, 7'h0A, 8'h0B, 8'h0C, 1'b1);
    req_valid = 4'b0010;
    step();
    chk("tmo m_start", 32'(m_start), 32'd1);
    req_valid = 4'd0;
    bad = 1'b0;
    for (int j = 0; j < 16; j++) begin
      step();
      if (resp_valid != 4'd0 || !busy) bad = 1'b1;
    end
    chk("tmo early resp", 32'(bad), 32'd0);
    step();
    chk("tmo resp_valid", 32'(resp_valid), 32'b0010);
    chk("tmo resp_err", 32'(resp_err), 32'd1);
    chk("tmo rdata", 32'(resp_rdata), 32'd0);
    step();
    run_txn('{0, 4'b0001, 2'd0, 7'h0D, 8'h0E, 8'h0F, 1'b1, 3, 8'h9A, 8'h9A}, "after_tmo");
`endif

    rst = 1'b1; step(); rst = 1'b0;
    mlast = 2'd3;
    for (int t = 0; t < 60; t++) begin
      r = 4'($urandom_range(0, 15));
      scramble();
      req_valid = r;
      m_done = 1'($urandom);
      m_dout = 8'($urandom);
      step();
      if (r == 4'd0) begin
        chk("rnd idle", 32'({m_start, busy, resp_valid}), 32'd0);
        continue;
      end
      w = rr(r, mlast);
      mlast = w;
      sa = a_arr[w]; sg = g_arr[w]; sw = w_arr[w]; srd = rd_arr[w];
      chk("rnd m_start", 32'(m_start), 32'd1);
      chk("rnd grant", 32'(grant_id), 32'(w));
      chk("rnd fields", 32'({m_addr, m_reg_addr, m_din, m_rd}), 32'({sa, sg, sw, srd}));
      req_valid = 4'($urandom);
      scramble();
      m_done = 1'($urandom);
      step();
      m_done = 1'b0;
      bad = (resp_valid != 4'd0) || m_start;
      l = $urandom_range(0, 3);
      for (int j = 0; j < l; j++) begin
        req_valid = 4'($urandom);
        step();
        if (resp_valid != 4'd0 || m_start) bad = 1'b1;
      end
      chk("rnd quiet", 32'(bad), 32'd0);
      d = 8'($urandom);
      m_done = 1'b1; m_dout = d; req_valid = 4'd0;
      step();
      chk("rnd resp_valid", 32'(resp_valid), 32'(4'b0001 << w));
      chk("rnd rdata", 32'({resp_err, resp_rdata}), 32'({1'b0, srd ? d : 8'h00}));
      chk("rnd stable", 32'({m_addr, m_reg_addr, m_din, m_rd}), 32'({sa, sg, sw, srd}));
      m_done = 1'($urandom);
      step();
      chk("rnd idle after", 32'({busy, resp_valid}), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
